// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the MIPS ALU control with iterative multiply/divide:
// ALUOp classes, funct codes, ALUOperation encodings and the engine state type.
package alu_ctrl_pkg;

  // ALUOp classes driven by the main control unit
  localparam logic [2:0] ALUOP_R    = 3'b111;
  localparam logic [2:0] ALUOP_ORI  = 3'b101;
  localparam logic [2:0] ALUOP_LUI  = 3'b000;
  localparam logic [2:0] ALUOP_ADDI = 3'b100;

  // R-type funct codes
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // ALUOperation encodings
  localparam logic [3:0] OPER_AND     = 4'b0000;
  localparam logic [3:0] OPER_OR      = 4'b0001;
  localparam logic [3:0] OPER_NOR     = 4'b0010;
  localparam logic [3:0] OPER_ADD     = 4'b0011;
  localparam logic [3:0] OPER_SUB     = 4'b0100;
  localparam logic [3:0] OPER_SLL     = 4'b0101;
  localparam logic [3:0] OPER_SRL     = 4'b0110;
  localparam logic [3:0] OPER_LUI     = 4'b0111;
  localparam logic [3:0] OPER_HILO    = 4'b1000;
  localparam logic [3:0] OPER_INVALID = 4'b1001;

  // Writeback mux select for HI/LO reads
  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_HI   = 2'b01;
  localparam logic [1:0] HILO_LO   = 2'b10;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;

  // MULT, MULTU, DIV and DIVU share the 0110xx funct prefix
  function automatic logic is_md_funct(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/mult_div_iter.sv
// Iterative multiply/divide engine: one bit per cycle on operand magnitudes,
// then a single sign-fix cycle that writes HI/LO and pulses o_done.
module mult_div_iter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_op_div,
  input  logic                  i_signed,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic                  o_dbz
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  md_state_t               r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_acc;     // partial product high half / remainder
  logic [DATA_WIDTH-1:0]   r_low;     // multiplier / dividend shifting into quotient
  logic [DATA_WIDTH-1:0]   r_opb;     // multiplicand / divisor magnitude
  logic                    r_is_div;
  logic                    r_neg_lo;  // negate product or quotient
  logic                    r_neg_hi;  // negate remainder (dividend sign)
  logic                    r_dbz;
  logic [DATA_WIDTH-1:0]   r_hi;
  logic [DATA_WIDTH-1:0]   r_lo;

  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [DATA_WIDTH-1:0]   w_a_mag;
  logic [DATA_WIDTH-1:0]   w_b_mag;
  logic [DATA_WIDTH:0]     w_sum;
  logic [DATA_WIDTH:0]     w_trial;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   w_quo;
  logic [DATA_WIDTH-1:0]   w_rem;

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // its correct unsigned magnitude.
  assign w_a_neg = i_signed & i_a[DATA_WIDTH-1];
  assign w_b_neg = i_signed & i_b[DATA_WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // Shift-add step: add multiplicand when the current multiplier bit is set
  assign w_sum = {1'b0, r_acc} + (r_low[0] ? {1'b0, r_opb} : '0);

  // Restoring-division trial subtract; MSB set means "restore"
  assign w_trial = {r_acc, r_low[DATA_WIDTH-1]} - {1'b0, r_opb};

  // Sign-corrected results used in the fix cycle. A zero divisor leaves the
  // dividend magnitude as remainder, so the dividend-sign fix restores DataA.
  assign w_prod = r_neg_lo ? -{r_acc, r_low} : {r_acc, r_low};
  assign w_quo  = r_dbz ? '1 : (r_neg_lo ? -r_low : r_low);
  assign w_rem  = r_neg_hi ? -r_acc : r_acc;

  // Engine FSM and datapath; HI/LO only change in FIX or on reset
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_low    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_acc    <= '0;
            r_low    <= i_op_div ? w_a_mag : w_b_mag;
            r_opb    <= i_op_div ? w_b_mag : w_a_mag;
            r_is_div <= i_op_div;
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_a_neg;
            r_dbz    <= i_op_div & (i_b == '0);
            r_cnt    <= CNT_W'(DATA_WIDTH - 1);
            r_state  <= i_op_div ? DIV : MUL;
          end
        end
        MUL: begin
          r_acc <= w_sum[DATA_WIDTH:1];
          r_low <= {w_sum[0], r_low[DATA_WIDTH-1:1]};
          if (r_cnt == '0) r_state <= FIX;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        DIV: begin
          if (!w_trial[DATA_WIDTH]) begin
            r_acc <= w_trial[DATA_WIDTH-1:0];
            r_low <= {r_low[DATA_WIDTH-2:0], 1'b1};
          end else begin
            r_acc <= {r_acc[DATA_WIDTH-2:0], r_low[DATA_WIDTH-1]};
            r_low <= {r_low[DATA_WIDTH-2:0], 1'b0};
          end
          if (r_cnt == '0) r_state <= FIX;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = (r_state == FIX);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_dbz  = r_dbz;

endmodule

// File: rtl/alu_control_md.sv
// ALU control for the execute stage: ALUOp/funct decode, HI/LO read select,
// stall generation and the iterative multiply/divide engine.
module alu_control_md
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ALUOP_WIDTH   = 3,
  parameter int ALUOPER_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ALUOP_WIDTH-1:0]   ALUOp,
  input  logic [5:0]               ALUFunction,
  input  logic                     InstrValid,
  input  logic [DATA_WIDTH-1:0]    DataA,
  input  logic [DATA_WIDTH-1:0]    DataB,
  output logic [ALUOPER_WIDTH-1:0] ALUOperation,
  output logic [1:0]               HiLoRead,
  output logic [DATA_WIDTH-1:0]    HI,
  output logic [DATA_WIDTH-1:0]    LO,
  output logic                     Stall,
  output logic                     MDBusy,
  output logic                     MDDone,
  output logic                     DivByZero
);

  logic       w_rtype;
  logic       w_is_md;
  logic       w_is_mf;
  logic       w_uses_hilo;
  logic       w_start;
  logic [3:0] w_oper;
  logic [1:0] w_hilo_sel;

  assign w_rtype = (ALUOp == ALUOP_WIDTH'(ALUOP_R));
  assign w_is_md = is_md_funct(ALUFunction);
  assign w_is_mf = (ALUFunction == F_MFHI) | (ALUFunction == F_MFLO);

  // Decode {ALUOp, ALUFunction} into the ALU select and the HI/LO read select
  always_comb begin
    w_oper     = OPER_INVALID;
    w_hilo_sel = HILO_NONE;
    if (w_rtype) begin
      case (ALUFunction)
        F_AND:  w_oper = OPER_AND;
        F_OR:   w_oper = OPER_OR;
        F_NOR:  w_oper = OPER_NOR;
        F_ADD:  w_oper = OPER_ADD;
        F_SUB:  w_oper = OPER_SUB;
        F_SLL:  w_oper = OPER_SLL;
        F_SRL:  w_oper = OPER_SRL;
        F_MFHI: begin
          w_oper     = OPER_HILO;
          w_hilo_sel = HILO_HI;
        end
        F_MFLO: begin
          w_oper     = OPER_HILO;
          w_hilo_sel = HILO_LO;
        end
        F_MULT, F_MULTU, F_DIV, F_DIVU: w_oper = OPER_HILO;
        default: w_oper = OPER_INVALID;
      endcase
    end else if (ALUOp == ALUOP_WIDTH'(ALUOP_ORI)) begin
      w_oper = OPER_OR;
    end else if (ALUOp == ALUOP_WIDTH'(ALUOP_LUI)) begin
      w_oper = OPER_LUI;
    end else if (ALUOp == ALUOP_WIDTH'(ALUOP_ADDI)) begin
      w_oper = OPER_ADD;
    end
  end

  assign ALUOperation = ALUOPER_WIDTH'(w_oper);
  assign HiLoRead     = w_hilo_sel;

  // Only real R-type HI/LO instructions interact with the engine; anything
  // else flows past a running multiply/divide.
  assign w_uses_hilo = InstrValid & w_rtype & (w_is_md | w_is_mf);
  assign Stall       = MDBusy & w_uses_hilo;
  assign w_start     = w_uses_hilo & w_is_md & ~MDBusy;

  mult_div_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_md (
    .clk      (clk),
    .i_rst_n  (reset),
    .i_start  (w_start),
    .i_op_div (ALUFunction[1]),
    .i_signed (~ALUFunction[0]),
    .i_a      (DataA),
    .i_b      (DataB),
    .o_busy   (MDBusy),
    .o_done   (MDDone),
    .o_hi     (HI),
    .o_lo     (LO),
    .o_dbz    (DivByZero)
  );

endmodule

// File: tb/tb_alu_control_md.sv
// Directed self-checking bench for alu_control_md (DATA_WIDTH=32).
module tb_alu_control_md;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ALUOp;
  logic [5:0]  ALUFunction;
  logic        InstrValid;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic [3:0]  ALUOperation;
  logic [1:0]  HiLoRead;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Stall;
  logic        MDBusy;
  logic        MDDone;
  logic        DivByZero;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // {ALUOp, funct, expected ALUOperation, expected HiLoRead}
  logic [14:0] dec_tab [19] = '{
    {3'b111, 6'b100100, 4'b0000, 2'b00},
    {3'b111, 6'b100101, 4'b0001, 2'b00},
    {3'b111, 6'b100111, 4'b0010, 2'b00},
    {3'b111, 6'b100000, 4'b0011, 2'b00},
    {3'b111, 6'b100010, 4'b0100, 2'b00},
    {3'b111, 6'b000000, 4'b0101, 2'b00},
    {3'b111, 6'b000010, 4'b0110, 2'b00},
    {3'b111, 6'b010000, 4'b1000, 2'b01},
    {3'b111, 6'b010010, 4'b1000, 2'b10},
    {3'b111, 6'b011000, 4'b1000, 2'b00},
    {3'b111, 6'b011001, 4'b1000, 2'b00},
    {3'b111, 6'b011010, 4'b1000, 2'b00},
    {3'b111, 6'b011011, 4'b1000, 2'b00},
    {3'b101, 6'b111111, 4'b0001, 2'b00},
    {3'b000, 6'b100100, 4'b0111, 2'b00},
    {3'b100, 6'b101010, 4'b0011, 2'b00},
    {3'b100, 6'b010000, 4'b0011, 2'b00},
    {3'b111, 6'b101010, 4'b1001, 2'b00},
    {3'b010, 6'b000000, 4'b1001, 2'b00}
  };

  alu_control_md dut (
    .clk          (clk),
    .reset        (reset),
    .ALUOp        (ALUOp),
    .ALUFunction  (ALUFunction),
    .InstrValid   (InstrValid),
    .DataA        (DataA),
    .DataB        (DataB),
    .ALUOperation (ALUOperation),
    .HiLoRead     (HiLoRead),
    .HI           (HI),
    .LO           (LO),
    .Stall        (Stall),
    .MDBusy       (MDBusy),
    .MDDone       (MDDone),
    .DivByZero    (DivByZero)
  );

  always #5 clk = ~clk;

  // Start of a new cycle: inputs are driven here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling (well before negedge)
  task automatic settle();
    #3;
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] f, input logic v,
                       input logic [31:0] a, input logic [31:0] b);
    ALUOp       = op;
    ALUFunction = f;
    InstrValid  = v;
    DataA       = a;
    DataB       = b;
  endtask

  // Issue one MD instruction in cycle N as a single-cycle instruction, then
  // observe cycles N+1..N+40. HI/LO are captured one cycle after MDDone.
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int done_at, output int done_cnt,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic busy_ok);
    done_at  = 0;
    done_cnt = 0;
    busy_ok  = 1'b1;
    hi       = '0;
    lo       = '0;
    tick();
    drive(3'b111, f, 1'b1, a, b);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) InstrValid = 1'b0;
      settle();
      if (k == 1 && MDBusy !== 1'b1) busy_ok = 1'b0;
      if (MDDone === 1'b1) begin
        if (done_at == 0) done_at = k;
        done_cnt++;
      end
      if (done_at != 0 && k == done_at + 1) begin
        hi = HI;
        lo = LO;
        if (MDBusy !== 1'b0) busy_ok = 1'b0;
      end
    end
    $display("md funct=%b A=%h B=%h -> HI=%h LO=%h dbz=%b done@N+%0d",
             f, a, b, hi, lo, DivByZero, done_at);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(3'b000, 6'b000000, 1'b0, '0, '0);
    tick();
    tick();
    settle();
    n_vec++; if (HI !== 32'h0)       begin n_err++; $display("FAIL reset_hi: got %h want 00000000", HI); end
    n_vec++; if (LO !== 32'h0)       begin n_err++; $display("FAIL reset_lo: got %h want 00000000", LO); end
    n_vec++; if (MDBusy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b want 0", MDBusy); end
    n_vec++; if (MDDone !== 1'b0)    begin n_err++; $display("FAIL reset_done: got %b want 0", MDDone); end
    n_vec++; if (DivByZero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b want 0", DivByZero); end
    tick();
    reset = 1'b1;
    $display("reset released");
  endtask

  task automatic test_decode();
    for (int i = 0; i < 19; i++) begin
      logic [14:0] e;
      e = dec_tab[i];
      tick();
      drive(e[14:12], e[11:6], 1'b0, '0, '0);
      settle();
      $display("decode ALUOp=%b funct=%b -> oper=%b hilo=%b", e[14:12], e[11:6], ALUOperation, HiLoRead);
      n_vec++; if (ALUOperation !== e[5:2]) begin n_err++; $display("FAIL decode_oper[%0d]: got %b want %b", i, ALUOperation, e[5:2]); end
      n_vec++; if (HiLoRead !== e[1:0])     begin n_err++; $display("FAIL decode_hilo[%0d]: got %b want %b", i, HiLoRead, e[1:0]); end
    end
  endtask

  task automatic test_mult();
    int d_at, d_cnt;
    logic [31:0] hi, lo;
    logic b_ok;
    run_md(FN_MULT, 32'hFFFFFFFE, 32'h3, d_at, d_cnt, hi, lo, b_ok);
    n_vec++; if (d_at !== 33)          begin n_err++; $display("FAIL mult_latency: got %0d want 33", d_at); end
    n_vec++; if (d_cnt !== 1)          begin n_err++; $display("FAIL mult_done_width: got %0d want 1", d_cnt); end
    n_vec++; if (b_ok !== 1'b1)        begin n_err++; $display("FAIL mult_busy: got %b want 1", b_ok); end
    n_vec++; if (hi !== 32'hFFFFFFFF)  begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_vec++; if (lo !== 32'hFFFFFFFA)  begin n_err++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
    run_md(FN_MULTU, 32'hFFFFFFFE, 32'h3, d_at, d_cnt, hi, lo, b_ok);
    n_vec++; if (d_at !== 33)          begin n_err++; $display("FAIL multu_latency: got %0d want 33", d_at); end
    n_vec++; if (hi !== 32'h00000002)  begin n_err++; $display("FAIL multu_hi: got %h want 00000002", hi); end
    n_vec++; if (lo !== 32'hFFFFFFFA)  begin n_err++; $display("FAIL multu_lo: got %h want fffffffa", lo); end
    run_md(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, d_at, d_cnt, hi, lo, b_ok);
    n_vec++; if (hi !== 32'hFFFFFFFE)  begin n_err++; $display("FAIL multu_max_hi: got %h want fffffffe", hi); end
    n_vec++; if (lo !== 32'h00000001)  begin n_err++; $display("FAIL multu_max_lo: got %h want 00000001", lo); end
  endtask

  task automatic test_div();
    int d_at, d_cnt;
    logic [31:0] hi, lo;
    logic b_ok;
    run_md(FN_DIV, 32'hFFFFFFF9, 32'h2, d_at, d_cnt, hi, lo, b_ok);
    n_vec++; if (d_at !== 33)          begin n_err++; $display("FAIL div_latency: got %0d want 33", d_at); end
    n_vec++; if (lo !== 32'hFFFFFFFD)  begin n_err++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    n_vec++; if (hi !== 32'hFFFFFFFF)  begin n_err++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    run_md(FN_DIV, 32'h7, 32'hFFFFFFFE, d_at, d_cnt, hi, lo, b_ok);
    n_vec++; if (lo !== 32'hFFFFFFFD)  begin n_err++; $display("FAIL div_negb_lo: got %h want fffffffd", lo); end
    n_vec++; if (hi !== 32'h00000001)  begin n_err++; $display("FAIL div_negb_hi: got %h want 00000001", hi); end
    run_md(FN_DIVU, 32'd100, 32'd7, d_at, d_cnt, hi, lo, b_ok);
    n_vec++; if (lo !== 32'd14)        begin n_err++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
    n_vec++; if (hi !== 32'd2)         begin n_err++; $display("FAIL divu_hi: got %h want 00000002", hi); end
    run_md(FN_DIVU, 32'h7, 32'h0, d_at, d_cnt, hi, lo, b_ok);
    n_vec++; if (d_at !== 33)          begin n_err++; $display("FAIL dbz_latency: got %0d want 33", d_at); end
    n_vec++; if (DivByZero !== 1'b1)   begin n_err++; $display("FAIL dbz_flag: got %b want 1", DivByZero); end
    n_vec++; if (hi !== 32'h00000007)  begin n_err++; $display("FAIL dbz_hi: got %h want 00000007", hi); end
    n_vec++; if (lo !== 32'hFFFFFFFF)  begin n_err++; $display("FAIL dbz_lo: got %h want ffffffff", lo); end
    run_md(FN_DIV, 32'hFFFFFFF9, 32'h0, d_at, d_cnt, hi, lo, b_ok);
    n_vec++; if (DivByZero !== 1'b1)   begin n_err++; $display("FAIL dbz_s_flag: got %b want 1", DivByZero); end
    n_vec++; if (hi !== 32'hFFFFFFF9)  begin n_err++; $display("FAIL dbz_s_hi: got %h want fffffff9", hi); end
    n_vec++; if (lo !== 32'hFFFFFFFF)  begin n_err++; $display("FAIL dbz_s_lo: got %h want ffffffff", lo); end
    run_md(FN_DIV, 32'h80000000, 32'hFFFFFFFF, d_at, d_cnt, hi, lo, b_ok);
    n_vec++; if (DivByZero !== 1'b0)   begin n_err++; $display("FAIL minneg_dbz: got %b want 0", DivByZero); end
    n_vec++; if (lo !== 32'h80000000)  begin n_err++; $display("FAIL minneg_lo: got %h want 80000000", lo); end
    n_vec++; if (hi !== 32'h00000000)  begin n_err++; $display("FAIL minneg_hi: got %h want 00000000", hi); end
  endtask

  // DIV in cycle N, MFLO held from N+1 (ADD replaces it in N+5)
  task automatic test_stall();
    tick();
    drive(3'b111, FN_DIV, 1'b1, 32'd100, 32'd7);
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (k == 5)       drive(3'b111, FN_ADD, 1'b1, 32'h0, 32'h0);
      else if (k <= 34) drive(3'b111, FN_MFLO, 1'b1, 32'h0, 32'h0);
      else              InstrValid = 1'b0;
      settle();
      if (k == 5) begin
        n_vec++; if (Stall !== 1'b0)         begin n_err++; $display("FAIL stall_add: got %b want 0", Stall); end
        n_vec++; if (ALUOperation !== 4'b0011) begin n_err++; $display("FAIL stall_add_oper: got %b want 0011", ALUOperation); end
      end else if (k <= 33) begin
        n_vec++; if (Stall !== 1'b1)         begin n_err++; $display("FAIL stall_mflo@N+%0d: got %b want 1", k, Stall); end
      end else if (k == 34) begin
        n_vec++; if (Stall !== 1'b0)         begin n_err++; $display("FAIL stall_release: got %b want 0", Stall); end
        n_vec++; if (HiLoRead !== 2'b10)     begin n_err++; $display("FAIL stall_hilo: got %b want 10", HiLoRead); end
        n_vec++; if (LO !== 32'd14)          begin n_err++; $display("FAIL stall_lo: got %h want 0000000e", LO); end
        $display("stall MFLO released at N+34 LO=%h", LO);
      end
    end
  endtask

  // MULT in cycle N, second MULT held from N+1 until accepted
  task automatic test_back_to_back();
    int done1, done2, d_cnt, gaps, gap_at;
    done1 = 0; done2 = 0; d_cnt = 0; gaps = 0; gap_at = 0;
    tick();
    drive(3'b111, FN_MULT, 1'b1, 32'd5, 32'd6);
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (k <= 34) drive(3'b111, FN_MULT, 1'b1, 32'd7, 32'd8);
      else         InstrValid = 1'b0;
      settle();
      if (MDDone === 1'b1) begin
        d_cnt++;
        if (done1 == 0) done1 = k; else if (done2 == 0) done2 = k;
      end
      if (k <= 67 && MDBusy !== 1'b1) begin
        gaps++;
        gap_at = k;
      end
      if (k == 33) begin
        n_vec++; if (Stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall_fix: got %b want 1", Stall); end
      end
      if (k == 34) begin
        n_vec++; if (Stall !== 1'b0)   begin n_err++; $display("FAIL b2b_accept: got %b want 0", Stall); end
        n_vec++; if (LO !== 32'd30)    begin n_err++; $display("FAIL b2b_lo1: got %h want 0000001e", LO); end
      end
      if (k == 68) begin
        n_vec++; if (LO !== 32'd56)    begin n_err++; $display("FAIL b2b_lo2: got %h want 00000038", LO); end
        n_vec++; if (HI !== 32'd0)     begin n_err++; $display("FAIL b2b_hi2: got %h want 00000000", HI); end
        n_vec++; if (MDBusy !== 1'b0)  begin n_err++; $display("FAIL b2b_idle: got %b want 0", MDBusy); end
      end
    end
    $display("b2b done@N+%0d,N+%0d busy gaps=%0d at N+%0d", done1, done2, gaps, gap_at);
    n_vec++; if (d_cnt !== 2)  begin n_err++; $display("FAIL b2b_done_cnt: got %0d want 2", d_cnt); end
    n_vec++; if (done1 !== 33) begin n_err++; $display("FAIL b2b_done1: got %0d want 33", done1); end
    n_vec++; if (done2 !== 67) begin n_err++; $display("FAIL b2b_done2: got %0d want 67", done2); end
    n_vec++; if (gaps !== 1)   begin n_err++; $display("FAIL b2b_gaps: got %0d want 1", gaps); end
    n_vec++; if (gap_at !== 34) begin n_err++; $display("FAIL b2b_gap_at: got %0d want 34", gap_at); end
  endtask

  // MULT running, reset held low for 2 cycles starting in N+5
  task automatic test_reset_abort();
    int seen_done, seen_busy, d_at, d_cnt;
    logic [31:0] hi, lo;
    logic b_ok;
    seen_done = 0; seen_busy = 0;
    tick();
    drive(3'b111, FN_MULT, 1'b1, 32'hFFFFFFFE, 32'h3);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) InstrValid = 1'b0;
      if (k == 5) reset = 1'b0;
    end
    tick();
    settle();
    n_vec++; if (MDBusy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", MDBusy); end
    n_vec++; if (HI !== 32'h0)    begin n_err++; $display("FAIL abort_hi: got %h want 00000000", HI); end
    n_vec++; if (LO !== 32'h0)    begin n_err++; $display("FAIL abort_lo: got %h want 00000000", LO); end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      settle();
      if (MDDone === 1'b1) seen_done++;
      if (MDBusy === 1'b1) seen_busy++;
      tick();
    end
    $display("reset abort: done pulses=%0d busy cycles=%0d after release", seen_done, seen_busy);
    n_vec++; if (seen_done !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", seen_done); end
    n_vec++; if (seen_busy !== 0) begin n_err++; $display("FAIL abort_idle: got %0d want 0", seen_busy); end
    run_md(FN_MULTU, 32'd5, 32'd7, d_at, d_cnt, hi, lo, b_ok);
    n_vec++; if (d_at !== 33)    begin n_err++; $display("FAIL abort_restart_lat: got %0d want 33", d_at); end
    n_vec++; if (lo !== 32'd35)  begin n_err++; $display("FAIL abort_restart_lo: got %h want 00000023", lo); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_div();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
